time_keeper_counter: RTL and testbench

//  Consumer end of the clock-divider output. Samples the divided clock (div_clk) in
//  the system clk domain, detects its rising edges, and advances a cascaded

---
 rtl/clock_pkg.sv | 10 +
 rtl/mod_counter.sv | 35 +++
 rtl/time_keeper_counter.sv | 65 ++++++
 tb/tb_time_keeper_counter.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Time-of-day moduli and field widths shared by the divider, time keeper and
// alarm-compare logic.
package clock_pkg;
   localparam int SEC_MAX  = 60;
   localparam int MIN_MAX  = 60;
   localparam int HOUR_MAX = 24;
   localparam int SEC_W    = 6;
   localparam int MIN_W    = 6;
   localparam int HOUR_W   = 5;
endpackage

// File: rtl/mod_counter.sv
// Modulo-MAX counter stage with a load port. Loads that are out of range are
// ignored. carry flags the increment that wraps MAX-1 back to 0.
module mod_counter #(
   parameter int WIDTH = 6,
   parameter int MAX   = 60
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] q,
   output logic             carry
);
   localparam logic [WIDTH-1:0] LAST = WIDTH'(MAX - 1);

   logic [WIDTH-1:0] q_q, q_d;

   always_comb begin
      q_d = q_q;
      if (load) begin
         if (int'(load_val) < MAX) q_d = load_val;
      end else if (inc) begin
         q_d = (q_q == LAST) ? '0 : q_q + WIDTH'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) q_q <= '0;
      else     q_q <= q_d;
   end

   assign q     = q_q;
   assign carry = inc & (q_q == LAST);
endmodule

// File: rtl/time_keeper_counter.sv
// Counts seconds/minutes/hours, one second per rising edge of div_clk as seen
// in the clk domain, with synchronous time set and a day-wrap pulse.
module time_keeper_counter
   import clock_pkg::*;
#(
   parameter int SEC_MAX_P  = SEC_MAX,
   parameter int MIN_MAX_P  = MIN_MAX,
   parameter int HOUR_MAX_P = HOUR_MAX
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              div_clk,
   input  logic              set_en,
   input  logic [HOUR_W-1:0] set_hour,
   input  logic [MIN_W-1:0]  set_min,
   output logic [SEC_W-1:0]  sec,
   output logic [MIN_W-1:0]  min,
   output logic [HOUR_W-1:0] hour,
   output logic              tick,
   output logic              day_wrap
);
   logic div_q_q;
   logic tick_q, tick_d;
   logic wrap_q, wrap_d;
   logic rise, adv;
   logic c_sec, c_min, c_hour;

   // div_q resets high so a div_clk already high at reset release is not an edge.
   assign rise = div_clk & ~div_q_q;
   assign adv  = rise & en & ~set_en;

   mod_counter #(.WIDTH(SEC_W), .MAX(SEC_MAX_P)) u_sec (
      .clk(clk), .rst(rst), .inc(adv), .load(set_en),
      .load_val('0), .q(sec), .carry(c_sec)
   );

   mod_counter #(.WIDTH(MIN_W), .MAX(MIN_MAX_P)) u_min (
      .clk(clk), .rst(rst), .inc(c_sec), .load(set_en),
      .load_val(set_min), .q(min), .carry(c_min)
   );

   mod_counter #(.WIDTH(HOUR_W), .MAX(HOUR_MAX_P)) u_hour (
      .clk(clk), .rst(rst), .inc(c_min), .load(set_en),
      .load_val(set_hour), .q(hour), .carry(c_hour)
   );

   assign tick_d = adv;
   assign wrap_d = c_hour;

   always_ff @(posedge clk) begin
      if (rst) begin
         div_q_q <= 1'b1;
         tick_q  <= 1'b0;
         wrap_q  <= 1'b0;
      end else begin
         div_q_q <= div_clk;
         tick_q  <= tick_d;
         wrap_q  <= wrap_d;
      end
   end

   assign tick     = tick_q;
   assign day_wrap = wrap_q;
endmodule

// File: tb/tb_time_keeper_counter.sv
// Scoreboard bench: the driver predicts each cycle's outputs from a seconds-of-day
// model and queues them; the monitor checks the DUT one step after every clk edge.
module tb_time_keeper_counter;
   logic       clk = 1'b0;
   logic       rst = 1'b1, en = 1'b0, div_clk = 1'b1, set_en = 1'b0;
   logic [4:0] set_hour = '0;
   logic [5:0] set_min = '0;
   logic [5:0] sec, min;
   logic [4:0] hour;
   logic       tick, day_wrap;

   always #5 clk = ~clk;

   time_keeper_counter dut (
      .clk(clk), .rst(rst), .en(en), .div_clk(div_clk), .set_en(set_en),
      .set_hour(set_hour), .set_min(set_min), .sec(sec), .min(min),
      .hour(hour), .tick(tick), .day_wrap(day_wrap)
   );

   typedef struct {
      int s; int m; int h; bit tick; bit wrap;
   } exp_t;

   exp_t q[$];
   int   tod = 0;
   bit   prev_div = 1'b1;
   int   n_chk = 0, n_fail = 0;
   int   dut_ticks = 0, dut_wraps = 0;

   // Model: time of day as a plain seconds count in 0..86399.
   task automatic step(input bit r, input bit e, input bit d, input bit se,
                       input int sh, input int sm);
      exp_t x;
      bit   rise;
      int   h, m;
      rst = r; en = e; div_clk = d; set_en = se;
      set_hour = 5'(sh); set_min = 6'(sm);
      x.tick = 0; x.wrap = 0;
      if (r) begin
         tod = 0; prev_div = 1'b1;
      end else begin
         rise = d && !prev_div;
         prev_div = d;
         if (se) begin
            h = tod / 3600; m = (tod / 60) % 60;
            if (sh < 24) h = sh;
            if (sm < 60) m = sm;
            tod = h * 3600 + m * 60;
         end else if (rise && e) begin
            tod = (tod + 1) % 86400;
            x.tick = 1;
            x.wrap = (tod == 0);
         end
      end
      x.h = tod / 3600; x.m = (tod / 60) % 60; x.s = tod % 60;
      q.push_back(x);
      @(negedge clk);
   endtask

   // n full div_clk periods (low half then high half) of length per.
   task automatic rises(input int n, input bit e, input int per);
      for (int i = 0; i < n; i++) begin
         for (int k = 0; k < per / 2; k++) step(0, e, 0, 0, 0, 0);
         for (int k = 0; k < per - per / 2; k++) step(0, e, 1, 0, 0, 0);
      end
   endtask

   always @(posedge clk) begin
      #1;
      if (tick === 1'b1) dut_ticks++;
      if (day_wrap === 1'b1) dut_wraps++;
      if (q.size() != 0) begin
         exp_t x;
         x = q.pop_front();
         n_chk++;
         if (sec !== 6'(x.s) || min !== 6'(x.m) || hour !== 5'(x.h) ||
             tick !== x.tick || day_wrap !== x.wrap) begin
            n_fail++;
            $display("FAIL state @%0t: got %0d:%0d:%0d tick=%b wrap=%b, expected %0d:%0d:%0d tick=%b wrap=%b",
                     $time, hour, min, sec, tick, day_wrap, x.h, x.m, x.s, x.tick, x.wrap);
         end
      end
   end

   task automatic check_cnt(input string name, input int got, input int exp);
      n_chk++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, got, exp);
      end
   endtask

   int t0, w0;

   initial begin
      @(negedge clk);
      // 1: reset with div_clk high, then hold high: no edge, no tick
      step(1, 0, 1, 0, 0, 0);
      step(1, 0, 1, 0, 0, 0);
      t0 = dut_ticks;
      for (int i = 0; i < 5; i++) step(0, 1, 1, 0, 0, 0);
      check_cnt("no_tick_after_reset", dut_ticks - t0, 0);

      // 2: three rises with period 10
      t0 = dut_ticks;
      rises(3, 1, 10);
      check_cnt("three_ticks", dut_ticks - t0, 3);

      // 3: 23:59:00 then 60 rises -> day wrap
      step(0, 1, 0, 1, 23, 59);
      w0 = dut_wraps;
      rises(60, 1, 4);
      step(0, 1, 0, 0, 0, 0);
      check_cnt("one_day_wrap", dut_wraps - w0, 1);

      // 4: rise coincident with set is dropped
      step(0, 1, 0, 0, 0, 0);
      t0 = dut_ticks;
      step(0, 1, 1, 1, 7, 30);
      step(0, 1, 1, 0, 0, 0);
      check_cnt("set_drops_rise", dut_ticks - t0, 0);
      rises(1, 1, 4);

      // 5: out-of-range hour keeps old hour
      step(0, 1, 0, 1, 5, 10);
      rises(42, 1, 2);
      step(0, 1, 0, 1, 24, 15);
      step(0, 1, 0, 1, 3, 60);
      step(0, 1, 0, 1, 31, 63);

      // 6: en=0 over rises, re-enable while div_clk high
      t0 = dut_ticks;
      rises(4, 0, 6);
      for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 0, 0);
      check_cnt("no_phantom_tick", dut_ticks - t0, 0);
      rises(1, 1, 4);
      check_cnt("one_tick_after_enable", dut_ticks - t0, 1);

      // random traffic, biased toward wrap boundaries
      for (int i = 0; i < 4000; i++) begin
         bit r, e, d, se;
         int sh, sm;
         r  = ($urandom_range(0, 499) == 0);
         e  = ($urandom_range(0, 9) != 0);
         d  = ($urandom_range(0, 2) == 0) ? ~div_clk : div_clk;
         se = ($urandom_range(0, 79) == 0);
         sh = ($urandom_range(0, 1) != 0) ? 23 : $urandom_range(0, 31);
         sm = ($urandom_range(0, 1) != 0) ? 59 : $urandom_range(0, 63);
         step(r, e, d, se, sh, sm);
      end

      step(0, 0, 0, 0, 0, 0);
      @(negedge clk);
      check_cnt("scoreboard_drained", q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
